wptr_ctrl: RTL and testbench

WPTR_CTRL -- requirements
Module: wptr_ctrl

---
 rtl/wptr_ctrl_if.sv | 44 ++++
 rtl/wptr_ctrl.sv | 87 ++++++++
 tb/tb_wptr_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wptr_ctrl_if.sv
// wptr_ctrl_if: bundles the write-side pointer controller signals.
//   master modport: the write client and the read-pointer synchroniser. It drives w_en, ovf_clr
//                   and g_rptr_sync, and it observes the pointer and flag outputs.
//   slave modport:  wptr_ctrl itself.
// Signals:
//   w_en         write request
//   ovf_clr      clears the sticky overflow flag
//   g_rptr_sync  Gray read pointer, already synchronised into the write clock domain
//   b_wptr       binary write pointer
//   g_wptr       Gray write pointer
//   waddr        memory write address
//   w_accept     the write is accepted this cycle
//   full         full flag
//   almost_full  almost-full flag
//   wlevel       fill level as seen from the write side
//   overflow     sticky flag, set when a write was attempted while full
`timescale 1ns/1ps
interface wptr_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 4
) ();
   localparam int unsigned Pw = ADDR_WIDTH + 1;

   logic                  w_en;
   logic                  ovf_clr;
   logic [Pw-1:0]         g_rptr_sync;
   logic [Pw-1:0]         b_wptr;
   logic [Pw-1:0]         g_wptr;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  w_accept;
   logic                  full;
   logic                  almost_full;
   logic [Pw-1:0]         wlevel;
   logic                  overflow;

   modport master (
      output w_en, ovf_clr, g_rptr_sync,
      input  b_wptr, g_wptr, waddr, w_accept, full, almost_full, wlevel, overflow
   );

   modport slave (
      input  w_en, ovf_clr, g_rptr_sync,
      output b_wptr, g_wptr, waddr, w_accept, full, almost_full, wlevel, overflow
   );
endinterface

// File: rtl/wptr_ctrl.sv
// wptr_ctrl: write-side pointer and flag controller for an asynchronous FIFO.
// The controller keeps the binary and Gray write pointers. It derives the full, almost-full and
// fill-level values from the read pointer after that pointer is synchronised into the write
// domain. It also records attempts to write into a full FIFO.
// Ports:
//   wclk  write-domain clock; all state updates on its rising edge
//   wrst  asynchronous active-high reset. Its release must already be synchronous to wclk.
//   bus   wptr_ctrl_if.slave: w_en, ovf_clr, g_rptr_sync in; b_wptr, g_wptr, waddr,
//         w_accept, full, almost_full, wlevel, overflow out
// Parameters:
//   ADDR_WIDTH  address width; depth = 2**ADDR_WIDTH, pointer width = ADDR_WIDTH+1
//   AFULL_TH    fill level at or above which almost_full asserts (1..depth)
`timescale 1ns/1ps
module wptr_ctrl #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned AFULL_TH   = (1 << ADDR_WIDTH) - 2
) (
   input logic        wclk,
   input logic        wrst,
   wptr_ctrl_if.slave bus
);
   localparam int unsigned Pw = ADDR_WIDTH + 1;
   // The write pointer is full when it equals the read pointer with its two MSBs inverted.
   // This XOR mask selects those two MSBs, and it still works when Pw is 2.
   localparam logic [Pw-1:0] FullMask = Pw'(3) << (Pw - 2);
   localparam logic [Pw-1:0] AfullTh  = Pw'(AFULL_TH);

   logic [Pw-1:0] b_wptr_q, b_wptr_d;
   logic [Pw-1:0] g_wptr_q, g_wptr_d;
   logic [Pw-1:0] wlevel_q, wlevel_d;
   logic [Pw-1:0] b_rptr_sync;
   logic          full_q, full_d;
   logic          afull_q, afull_d;
   logic          ovf_q, ovf_d;
   logic          w_accept;

   // Gray-to-binary decode: binary bit i is the XOR of Gray bits Pw-1 down to i.
   always_comb begin
      b_rptr_sync = '0;
      for (int i = 0; i < int'(Pw); i++) begin
         b_rptr_sync[i] = ^(bus.g_rptr_sync >> i);
      end
   end

   // Writes are accepted only against the registered full flag. The flag is pessimistic, so
   // a write can never be accepted into a FIFO that is really full.
   assign w_accept = bus.w_en & ~full_q;

   always_comb begin
      b_wptr_d = b_wptr_q + Pw'(w_accept);
      g_wptr_d = (b_wptr_d >> 1) ^ b_wptr_d;
      // Compare the Gray codes directly, so the flag does not depend on the binary decode of
      // the synchronised pointer.
      full_d   = (g_wptr_d == (bus.g_rptr_sync ^ FullMask));
      wlevel_d = b_wptr_d - b_rptr_sync;
      afull_d  = (wlevel_d >= AfullTh);
      // A new overflow event wins over a clear in the same cycle.
      ovf_d    = (bus.w_en & full_q) | (ovf_q & ~bus.ovf_clr);
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         b_wptr_q <= '0;
         g_wptr_q <= '0;
         wlevel_q <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         b_wptr_q <= b_wptr_d;
         g_wptr_q <= g_wptr_d;
         wlevel_q <= wlevel_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.b_wptr      = b_wptr_q;
   assign bus.g_wptr      = g_wptr_q;
   assign bus.waddr       = b_wptr_q[ADDR_WIDTH-1:0];
   assign bus.w_accept    = w_accept;
   assign bus.full        = full_q;
   assign bus.almost_full = afull_q;
   assign bus.wlevel      = wlevel_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_wptr_ctrl.sv
// tb_wptr_ctrl: directed testbench for wptr_ctrl.
// The main instance uses ADDR_WIDTH=3 and AFULL_TH=6. A second instance uses ADDR_WIDTH=1 and
// AFULL_TH=2.
`timescale 1ns/1ps
module tb_wptr_ctrl;
   logic wclk = 1'b0;
   logic wrst = 1'b1;
   always #5 wclk = ~wclk;

   wptr_ctrl_if #(.ADDR_WIDTH(3)) bus ();
   wptr_ctrl_if #(.ADDR_WIDTH(1)) nbus ();

   wptr_ctrl #(.ADDR_WIDTH(3), .AFULL_TH(6)) dut (.wclk(wclk), .wrst(wrst), .bus(bus));
   wptr_ctrl #(.ADDR_WIDTH(1), .AFULL_TH(2)) ndut (.wclk(wclk), .wrst(wrst), .bus(nbus));

   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] prev_g;
   bit         prev_ok = 1'b0;

   // Each clock step checks the Gray encoding and the single-bit-change property.
   task automatic tick();
      @(posedge wclk);
      #1;
      n_cmp++;
      if (bus.g_wptr !== (bus.b_wptr ^ (bus.b_wptr >> 1))) begin
         n_err++;
         $display("FAIL gray_enc: g_wptr=%b b_wptr=%b", bus.g_wptr, bus.b_wptr);
      end
      if (prev_ok) begin
         n_cmp++;
         if ($countones(prev_g ^ bus.g_wptr) > 1) begin
            n_err++;
            $display("FAIL gray_step: prev=%b now=%b", prev_g, bus.g_wptr);
         end
      end
      prev_g  = bus.g_wptr;
      prev_ok = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge wclk);
      wrst = 1'b1;
      bus.g_rptr_sync = '0;
      @(negedge wclk);
      wrst    = 1'b0;
      prev_ok = 1'b0;
   endtask

   task automatic test_reset();
      wrst = 1'b1;
      bus.w_en = 1'b0;  bus.ovf_clr = 1'b0;  bus.g_rptr_sync = '0;
      nbus.w_en = 1'b0; nbus.ovf_clr = 1'b0; nbus.g_rptr_sync = '0;
      #12;
      n_cmp++;
      if ({bus.b_wptr, bus.g_wptr, bus.waddr, bus.full, bus.almost_full, bus.wlevel,
           bus.overflow} !== 19'd0) begin
         n_err++;
         $display("FAIL reset_outputs: b=%h g=%h a=%h f=%b af=%b lvl=%h ovf=%b want all 0",
                  bus.b_wptr, bus.g_wptr, bus.waddr, bus.full, bus.almost_full, bus.wlevel,
                  bus.overflow);
      end
      n_cmp++;
      if (bus.w_accept !== 1'b0) begin
         n_err++; $display("FAIL reset_w_accept: got %b want 0", bus.w_accept);
      end
      @(negedge wclk);
      wrst = 1'b0;
   endtask

   task automatic test_fill();
      bus.g_rptr_sync = '0;
      bus.w_en = 1'b1;
      #1;
      for (int i = 1; i <= 10; i++) begin
         int e;
         e = (i < 8) ? i : 8;
         n_cmp++;
         if (bus.w_accept !== (i <= 8)) begin
            n_err++; $display("FAIL fill_accept[%0d]: got %b want %b", i, bus.w_accept, i <= 8);
         end
         tick();
         n_cmp++;
         if (bus.b_wptr !== 4'(e)) begin
            n_err++; $display("FAIL fill_b_wptr[%0d]: got %0d want %0d", i, bus.b_wptr, e);
         end
         n_cmp++;
         if (bus.waddr !== 3'(e % 8)) begin
            n_err++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, bus.waddr, e % 8);
         end
         n_cmp++;
         if (bus.wlevel !== 4'(e)) begin
            n_err++; $display("FAIL fill_wlevel[%0d]: got %0d want %0d", i, bus.wlevel, e);
         end
         n_cmp++;
         if (bus.full !== (i >= 8)) begin
            n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, i >= 8);
         end
         n_cmp++;
         if (bus.almost_full !== (e >= 6)) begin
            n_err++; $display("FAIL fill_afull[%0d]: got %b want %b", i, bus.almost_full, e >= 6);
         end
         n_cmp++;
         if (bus.overflow !== (i >= 9)) begin
            n_err++; $display("FAIL fill_ovf[%0d]: got %b want %b", i, bus.overflow, i >= 9);
         end
      end
      bus.w_en = 1'b0;
   endtask

   task automatic test_drain();
      bus.g_rptr_sync = 4'b0010;  // Gray(3)
      tick();
      n_cmp++;
      if ({bus.full, bus.almost_full, bus.wlevel, bus.b_wptr} !== {1'b0, 1'b0, 4'd5, 4'd8}) begin
         n_err++;
         $display("FAIL drain_flags: f=%b af=%b lvl=%0d b=%0d want 0 0 5 8",
                  bus.full, bus.almost_full, bus.wlevel, bus.b_wptr);
      end
      bus.w_en = 1'b1;
      #1;
      n_cmp++;
      if (bus.w_accept !== 1'b1) begin
         n_err++; $display("FAIL drain_accept: got %b want 1", bus.w_accept);
      end
      tick();
      bus.w_en = 1'b0;
      n_cmp++;
      if ({bus.full, bus.almost_full, bus.wlevel, bus.b_wptr} !== {1'b0, 1'b1, 4'd6, 4'd9}) begin
         n_err++;
         $display("FAIL drain_write: f=%b af=%b lvl=%0d b=%0d want 0 1 6 9",
                  bus.full, bus.almost_full, bus.wlevel, bus.b_wptr);
      end
   endtask

   task automatic test_ovf_clr();
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      n_cmp++;
      if (bus.overflow !== 1'b0) begin
         n_err++; $display("FAIL ovf_clear: got %b want 0", bus.overflow);
      end
      bus.w_en = 1'b1;
      tick();
      tick();
      bus.w_en = 1'b0;
      n_cmp++;
      if ({bus.full, bus.almost_full, bus.wlevel, bus.b_wptr} !== {1'b1, 1'b1, 4'd8, 4'd11})
      begin
         n_err++;
         $display("FAIL refill: f=%b af=%b lvl=%0d b=%0d want 1 1 8 11",
                  bus.full, bus.almost_full, bus.wlevel, bus.b_wptr);
      end
      bus.w_en = 1'b1;
      bus.ovf_clr = 1'b1;
      #1;
      n_cmp++;
      if (bus.w_accept !== 1'b0) begin
         n_err++; $display("FAIL full_accept: got %b want 0", bus.w_accept);
      end
      tick();
      n_cmp++;
      if ({bus.overflow, bus.b_wptr} !== {1'b1, 4'd11}) begin
         n_err++;
         $display("FAIL ovf_set_wins: ovf=%b b=%0d want 1 11", bus.overflow, bus.b_wptr);
      end
      bus.w_en = 1'b0;
      bus.ovf_clr = 1'b0;
      tick();
      n_cmp++;
      if (bus.overflow !== 1'b1) begin
         n_err++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow);
      end
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      n_cmp++;
      if (bus.overflow !== 1'b0) begin
         n_err++; $display("FAIL ovf_clear2: got %b want 0", bus.overflow);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.w_en = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         logic [3:0] g_before;
         logic [3:0] r;
         g_before = bus.g_wptr;
         tick();
         n_cmp++;
         if ({bus.b_wptr, bus.full, bus.wlevel} !== {4'(k), 1'b0, 4'((k < 3) ? k : 3)}) begin
            n_err++;
            $display("FAIL wrap_step[%0d]: b=%0d f=%b lvl=%0d want %0d 0 %0d", k, bus.b_wptr,
                     bus.full, bus.wlevel, k % 16, (k < 3) ? k : 3);
         end
         if ((k % 16) == 0) begin
            n_cmp++;
            if ({g_before, bus.g_wptr} !== 8'b1000_0000) begin
               n_err++;
               $display("FAIL wrap_gray[%0d]: %b->%b want 1000->0000", k, g_before, bus.g_wptr);
            end
         end
         r = 4'(k - 2);
         bus.g_rptr_sync = (k >= 2) ? (r ^ (r >> 1)) : 4'd0;
      end
      bus.w_en = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.w_en = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      bus.w_en = 1'b0;
      n_cmp++;
      if (bus.b_wptr !== 4'd5) begin
         n_err++; $display("FAIL areset_pre: b=%0d want 5", bus.b_wptr);
      end
      #2;
      wrst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.b_wptr, bus.g_wptr, bus.waddr, bus.full, bus.almost_full, bus.wlevel,
           bus.overflow} !== 19'd0) begin
         n_err++;
         $display("FAIL areset_outputs: b=%h g=%h a=%h f=%b af=%b lvl=%h ovf=%b want all 0",
                  bus.b_wptr, bus.g_wptr, bus.waddr, bus.full, bus.almost_full, bus.wlevel,
                  bus.overflow);
      end
      prev_ok = 1'b0;
      @(negedge wclk);
      wrst = 1'b0;
      bus.w_en = 1'b1;
      #1;
      n_cmp++;
      if ({bus.waddr, bus.w_accept} !== {3'd0, 1'b1}) begin
         n_err++;
         $display("FAIL areset_first: waddr=%0d acc=%b want 0 1", bus.waddr, bus.w_accept);
      end
      tick();
      bus.w_en = 1'b0;
      n_cmp++;
      if (bus.b_wptr !== 4'd1) begin
         n_err++; $display("FAIL areset_post: b=%0d want 1", bus.b_wptr);
      end
   endtask

   task automatic test_narrow();
      nbus.g_rptr_sync = 2'b00;
      nbus.w_en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         int e;
         e = (i < 2) ? i : 2;
         tick();
         n_cmp++;
         if ({nbus.b_wptr, nbus.wlevel, nbus.full, nbus.almost_full, nbus.overflow} !==
             {2'(e), 2'(e), i >= 2, i >= 2, i >= 3}) begin
            n_err++;
            $display("FAIL narrow[%0d]: b=%0d lvl=%0d f=%b af=%b ovf=%b want %0d %0d %b %b %b",
                     i, nbus.b_wptr, nbus.wlevel, nbus.full, nbus.almost_full, nbus.overflow,
                     e, e, i >= 2, i >= 2, i >= 3);
         end
      end
      nbus.w_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_ovf_clr();
      test_wrap();
      test_async_reset();
      test_narrow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end
endmodule
